// File: rtl/tv_addr_win.sv
// tv_addr_win: windows a TV decoder sample stream into fixed-length lines.
// Each accepted line start emits LINE_W decimated active pixels and then
// PAD_W zero pixels, with x/y addressing. Frame start and end pulses are
// decoded from the decoder's line/sample counters.
module tv_addr_win #(
    parameter int DW         = 16,
    parameter int XW         = 10,
    parameter int YW         = 11,
    parameter int LINE_W     = 720,
    parameter int PAD_W      = 3,
    parameter int DECIM      = 2,
    parameter int FIELD_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    tv_x,
    input  logic [9:0]    tv_y,
    input  logic [DW-1:0] tv_data,
    input  logic          tv_dval,
    input  logic          tv_field,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [DW-1:0] data_out,
    output logic          dval,
    output logic          new_frame,
    output logic          end_frame,
    output logic          end_line,
    output logic          line_err
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_PAD    = 2'd2;

    // Index of the last active pixel and of the last pixel of the line
    localparam logic [XW-1:0] LAST_ACT = XW'(LINE_W - 1);
    localparam logic [XW-1:0] LAST_PIX = XW'(LINE_W + PAD_W - 1);
    // Phase value on which the counter wraps and a pixel is emitted
    localparam logic [2:0]    PH_LAST  = 3'(DECIM - 1);
    // Field values that mark the first line / the end of a frame
    localparam logic          NF_FIELD = (FIELD_MODE == 1) ? 1'b1 : 1'b0;
    localparam logic          EF_FIELD = (FIELD_MODE == 0) ? 1'b0 : 1'b1;

    logic [1:0]    r_state;
    logic [2:0]    r_phase;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [DW-1:0] r_data;
    logic          r_dval;
    logic          r_new_frame;
    logic          r_end_frame;
    logic          r_end_line;
    logic          r_line_err;
    logic          r_nf_prev;
    logic          r_ef_prev;

    logic          w_field_ok;
    logic          w_line_start;
    logic          w_nf_cond;
    logic          w_ef_cond;
    logic [YW-1:0] w_ym1;
    logic [YW-1:0] w_y_start;
    logic          w_emit;
    logic [XW-1:0] w_idx;
    logic [1:0]    w_nxt_state;
    logic [2:0]    w_nxt_phase;
    logic [XW-1:0] w_nxt_x;
    logic [YW-1:0] w_nxt_y;
    logic [DW-1:0] w_nxt_data;
    logic          w_nxt_end_line;
    logic          w_nxt_line_err;

    // Decide whether the current field is one this instance windows
    always_comb begin
        if (FIELD_MODE == 0) begin
            w_field_ok = ~tv_field;
        end else if (FIELD_MODE == 1) begin
            w_field_ok = tv_field;
        end else begin
            w_field_ok = 1'b1;
        end
    end

    assign w_line_start = (tv_x == 10'd1) && tv_dval && (tv_y >= 10'd1) && w_field_ok;
    assign w_nf_cond    = (tv_x == 10'd1) && (tv_y == 10'd1) && (tv_field == NF_FIELD);
    assign w_ef_cond    = (tv_x == 10'd1) && (tv_y == 10'd0) && (tv_field == EF_FIELD);
    assign w_ym1        = YW'(tv_y) - YW'(1'b1);

    // Line number latched at line start; interleaved mode merges both fields
    always_comb begin
        if (FIELD_MODE == 2) begin
            w_y_start = (w_ym1 << 1) | YW'(tv_field);
        end else begin
            w_y_start = w_ym1;
        end
    end

    // Next-state logic: line (re)start, decimation cadence and pixel emission
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_phase    = r_phase;
        w_nxt_x        = r_x;
        w_nxt_y        = r_y;
        w_nxt_data     = r_data;
        w_nxt_end_line = 1'b0;
        w_nxt_line_err = 1'b0;
        w_emit         = 1'b0;
        w_idx          = r_x;
        if (w_line_start) begin
            // A start always wins; restarting a running line is flagged
            w_emit         = 1'b1;
            w_idx          = {XW{1'b0}};
            w_nxt_phase    = 3'd0;
            w_nxt_data     = tv_data;
            w_nxt_y        = w_y_start;
            w_nxt_line_err = (r_state != ST_IDLE);
        end else begin
            case (r_state)
                ST_ACTIVE, ST_PAD: begin
                    if (r_phase == PH_LAST) begin
                        w_nxt_phase = 3'd0;
                        w_emit      = 1'b1;
                        w_idx       = r_x + XW'(1'b1);
                        w_nxt_data  = (r_state == ST_ACTIVE) ? tv_data : {DW{1'b0}};
                    end else begin
                        w_nxt_phase = r_phase + 3'd1;
                    end
                end
                default: begin
                    w_nxt_phase = 3'd0;
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
        if (w_emit) begin
            // State names the kind of the pixel that will be emitted next
            w_nxt_x        = w_idx;
            w_nxt_end_line = (w_idx == LAST_PIX);
            if (w_idx < LAST_ACT) begin
                w_nxt_state = ST_ACTIVE;
            end else if (w_idx < LAST_PIX) begin
                w_nxt_state = ST_PAD;
            end else begin
                w_nxt_state = ST_IDLE;
            end
        end else begin
            w_nxt_x = r_x;
        end
    end

    // Pixel pipeline registers and FSM state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_phase    <= 3'd0;
            r_x        <= {XW{1'b0}};
            r_y        <= {YW{1'b0}};
            r_data     <= {DW{1'b0}};
            r_dval     <= 1'b0;
            r_end_line <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_phase    <= w_nxt_phase;
            r_x        <= w_nxt_x;
            r_y        <= w_nxt_y;
            r_data     <= w_nxt_data;
            r_dval     <= w_emit;
            r_end_line <= w_nxt_end_line;
            r_line_err <= w_nxt_line_err;
        end
    end

    // Frame markers: rising-edge detect so a held condition pulses once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_new_frame <= 1'b0;
            r_end_frame <= 1'b0;
            r_nf_prev   <= 1'b0;
            r_ef_prev   <= 1'b0;
        end else begin
            r_new_frame <= w_nf_cond & ~r_nf_prev;
            r_end_frame <= w_ef_cond & ~r_ef_prev;
            r_nf_prev   <= w_nf_cond;
            r_ef_prev   <= w_ef_cond;
        end
    end

    assign x         = r_x;
    assign y         = r_y;
    assign data_out  = r_data;
    assign dval      = r_dval;
    assign new_frame = r_new_frame;
    assign end_frame = r_end_frame;
    assign end_line  = r_end_line;
    assign line_err  = r_line_err;

endmodule

// File: tb/tb_tv_addr_win.sv
// Testbench for tv_addr_win: three differently configured instances share one
// stimulus stream; a timing-based reference model predicts every output.
module tb_tv_addr_win;

    localparam int NC = 3;
    // Instance configurations: 0 = 8+2 px /2 field0, 1 = 4+0 px /1 field0, 2 = 8+2 px /3 both
    int c_line [NC] = '{8, 4, 8};
    int c_pad  [NC] = '{2, 0, 2};
    int c_dec  [NC] = '{2, 1, 3};
    int c_mode [NC] = '{0, 0, 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  tv_x = 10'd0;
    logic [9:0]  tv_y = 10'd0;
    logic [15:0] tv_data = 16'd0;
    logic        tv_dval = 1'b0;
    logic        tv_field = 1'b0;

    logic [9:0]  o_x  [NC];
    logic [10:0] o_y  [NC];
    logic [15:0] o_d  [NC];
    logic        o_dv [NC];
    logic        o_nf [NC];
    logic        o_ef [NC];
    logic        o_el [NC];
    logic        o_le [NC];
    logic [41:0] obs  [NC];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tv_addr_win #(.DW(16), .XW(10), .YW(11), .LINE_W(8), .PAD_W(2), .DECIM(2), .FIELD_MODE(0)) u_a (
        .clk(clk), .reset(rst_n), .tv_x(tv_x), .tv_y(tv_y), .tv_data(tv_data), .tv_dval(tv_dval),
        .tv_field(tv_field), .x(o_x[0]), .y(o_y[0]), .data_out(o_d[0]), .dval(o_dv[0]),
        .new_frame(o_nf[0]), .end_frame(o_ef[0]), .end_line(o_el[0]), .line_err(o_le[0]));
    tv_addr_win #(.DW(16), .XW(10), .YW(11), .LINE_W(4), .PAD_W(0), .DECIM(1), .FIELD_MODE(0)) u_b (
        .clk(clk), .reset(rst_n), .tv_x(tv_x), .tv_y(tv_y), .tv_data(tv_data), .tv_dval(tv_dval),
        .tv_field(tv_field), .x(o_x[1]), .y(o_y[1]), .data_out(o_d[1]), .dval(o_dv[1]),
        .new_frame(o_nf[1]), .end_frame(o_ef[1]), .end_line(o_el[1]), .line_err(o_le[1]));
    tv_addr_win #(.DW(16), .XW(10), .YW(11), .LINE_W(8), .PAD_W(2), .DECIM(3), .FIELD_MODE(2)) u_c (
        .clk(clk), .reset(rst_n), .tv_x(tv_x), .tv_y(tv_y), .tv_data(tv_data), .tv_dval(tv_dval),
        .tv_field(tv_field), .x(o_x[2]), .y(o_y[2]), .data_out(o_d[2]), .dval(o_dv[2]),
        .new_frame(o_nf[2]), .end_frame(o_ef[2]), .end_line(o_el[2]), .line_err(o_le[2]));

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            obs[i] = {o_x[i], o_y[i], o_d[i], o_dv[i], o_nf[i], o_ef[i], o_el[i], o_le[i]};
        end
    end

    // Reference model: a line is a start cycle; pixel k is due DECIM*k cycles later
    int          cyc;
    int          m_start [NC];
    bit          m_busy  [NC];
    int          m_x     [NC];
    int          m_y     [NC];
    logic [15:0] m_data  [NC];
    bit          m_dval  [NC];
    bit          m_nf    [NC];
    bit          m_ef    [NC];
    bit          m_el    [NC];
    bit          m_le    [NC];
    bit          m_nfp   [NC];
    bit          m_efp   [NC];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int c = 0; c < NC; c++) begin
                m_start[c] <= 0; m_busy[c] <= 1'b0; m_x[c] <= 0; m_y[c] <= 0;
                m_data[c] <= 16'd0; m_dval[c] <= 1'b0; m_nf[c] <= 1'b0; m_ef[c] <= 1'b0;
                m_el[c] <= 1'b0; m_le[c] <= 1'b0; m_nfp[c] <= 1'b0; m_efp[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                bit acc, ls, nfc, efc, emit;
                int k, el, total;
                total = c_line[c] + c_pad[c];
                acc = (c_mode[c] == 2) || (tv_field == (c_mode[c] == 1));
                ls  = (tv_x == 10'd1) && tv_dval && (tv_y >= 10'd1) && acc;
                nfc = (tv_x == 10'd1) && (tv_y == 10'd1) && (tv_field == (c_mode[c] == 1));
                efc = (tv_x == 10'd1) && (tv_y == 10'd0) && (tv_field == (c_mode[c] != 0));
                m_nf[c]  <= nfc && !m_nfp[c];
                m_ef[c]  <= efc && !m_efp[c];
                m_nfp[c] <= nfc;
                m_efp[c] <= efc;
                m_le[c]  <= ls && m_busy[c];
                emit = 1'b0;
                k = 0;
                if (ls) begin
                    emit = 1'b1;
                    m_start[c] <= cyc;
                    if (c_mode[c] == 2) m_y[c] <= (2 * (int'(tv_y) - 1) + int'(tv_field)) % 2048;
                    else m_y[c] <= (int'(tv_y) - 1) % 2048;
                end else if (m_busy[c]) begin
                    el = cyc - m_start[c];
                    if (el % c_dec[c] == 0) begin
                        emit = 1'b1;
                        k = el / c_dec[c];
                    end
                end
                m_dval[c] <= emit;
                m_el[c]   <= emit && (k == total - 1);
                if (emit) begin
                    m_x[c]    <= k;
                    m_data[c] <= (k < c_line[c]) ? tv_data : 16'd0;
                    m_busy[c] <= (k < total - 1);
                end
            end
            cyc <= cyc + 1;
        end
    end

    function automatic logic [41:0] pk(input int c);
        return {10'(m_x[c]), 11'(m_y[c]), m_data[c], m_dval[c], m_nf[c], m_ef[c], m_el[c], m_le[c]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] xi, input logic [9:0] yi, input logic dvi, input logic fi);
        tv_x = xi; tv_y = yi; tv_dval = dvi; tv_field = fi; tv_data = 16'($urandom);
    endtask

    task automatic drive_idle();
        drive(10'($urandom_range(2, 700)), 10'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(10'd1, 10'd1, 1'b1, 1'b0);
        step();
        step();
        for (int i = 0; i < NC; i++) begin
            n_chk++;
            if (obs[i] !== 42'd0) $display("FAIL reset_cfg%0d: got %h want 0", i, obs[i]);
            else n_pass++;
        end
        drive(10'd0, 10'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_line();
        int na = 0, nb = 0, la = 0, lb = 0, ela = 0, elb = 0;
        drive(10'd1, 10'd5, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
            for (int c = 0; c < NC; c++) begin
                n_chk++;
                if (obs[c] !== pk(c)) $display("FAIL basic_model_cfg%0d: got %h want %h", c, obs[c], pk(c));
                else n_pass++;
            end
            if (o_dv[0]) begin
                n_chk++;
                if (o_x[0] !== 10'(na) || o_y[0] !== 11'd4 || (na > 0 && i - la != 2) ||
                    (na >= 8 && o_d[0] !== 16'd0) || (o_el[0] && na != 9))
                    $display("FAIL basic_pixel_a: got x=%0d y=%0d d=%h gap=%0d el=%0d want x=%0d y=4", o_x[0], o_y[0], o_d[0], i - la, o_el[0], na);
                else n_pass++;
                na++; la = i;
            end
            if (o_dv[1]) begin
                n_chk++;
                if (o_x[1] !== 10'(nb) || (nb > 0 && i - lb != 1) || (o_el[1] && nb != 3))
                    $display("FAIL basic_pixel_b: got x=%0d gap=%0d el=%0d want x=%0d", o_x[1], i - lb, o_el[1], nb);
                else n_pass++;
                nb++; lb = i;
            end
            if (o_el[0]) ela++;
            if (o_el[1]) elb++;
            drive_idle();
        end
        n_chk++;
        if (na != 10 || ela != 1) $display("FAIL basic_count_a: got %0d px %0d el want 10 px 1 el", na, ela);
        else n_pass++;
        n_chk++;
        if (nb != 4 || elb != 1) $display("FAIL basic_count_b: got %0d px %0d el want 4 px 1 el", nb, elb);
        else n_pass++;
    endtask

    task automatic test_mode2_y();
        drive(10'd1, 10'd3, 1'b1, 1'b0);
        step();
        n_chk++;
        if (o_y[2] !== 11'd4 || o_dv[2] !== 1'b1 || o_y[0] !== 11'd2)
            $display("FAIL mode2_field0: got c.y=%0d c.dval=%0d a.y=%0d want 4 1 2", o_y[2], o_dv[2], o_y[0]);
        else n_pass++;
        for (int i = 0; i < 35; i++) begin
            drive_idle();
            step();
            for (int c = 0; c < NC; c++) begin
                n_chk++;
                if (obs[c] !== pk(c)) $display("FAIL mode2_model_cfg%0d: got %h want %h", c, obs[c], pk(c));
                else n_pass++;
            end
        end
        drive(10'd1, 10'd3, 1'b1, 1'b1);
        step();
        n_chk++;
        if (o_y[2] !== 11'd5 || o_le[2] !== 1'b0 || o_y[0] !== 11'd2 || o_dv[0] !== 1'b0)
            $display("FAIL mode2_field1: got c.y=%0d c.err=%0d a.y=%0d a.dval=%0d want 5 0 2 0", o_y[2], o_le[2], o_y[0], o_dv[0]);
        else n_pass++;
    endtask

    task automatic test_line_err();
        int cnt = 0, els = 0;
        drive(10'd1, 10'd6, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            drive_idle();
            if (o_dv[0]) cnt++;
            if (cnt == 3) break;
        end
        n_chk++;
        if (cnt != 3) $display("FAIL err_wait_pixels: got %0d want 3", cnt);
        else n_pass++;
        drive(10'd1, 10'd6, 1'b1, 1'b0);
        step();
        for (int c = 0; c < NC; c++) begin
            n_chk++;
            if (obs[c] !== pk(c)) $display("FAIL err_model_cfg%0d: got %h want %h", c, obs[c], pk(c));
            else n_pass++;
        end
        n_chk++;
        if (o_le[0] !== 1'b1 || o_x[0] !== 10'd0 || o_dv[0] !== 1'b1 || o_el[0] !== 1'b0)
            $display("FAIL err_restart: got err=%0d x=%0d dval=%0d el=%0d want 1 0 1 0", o_le[0], o_x[0], o_dv[0], o_el[0]);
        else n_pass++;
        drive_idle();
        step();
        n_chk++;
        if (o_le[0] !== 1'b0) $display("FAIL err_single_pulse: got %0d want 0", o_le[0]);
        else n_pass++;
        for (int i = 0; i < 25; i++) begin
            if (o_el[0]) begin
                els++;
                n_chk++;
                if (o_x[0] !== 10'd9) $display("FAIL err_end_line_x: got %0d want 9", o_x[0]);
                else n_pass++;
            end
            drive_idle();
            step();
        end
        n_chk++;
        if (els != 1) $display("FAIL err_end_line_count: got %0d want 1", els);
        else n_pass++;
    endtask

    task automatic test_field_filter();
        int ndv = 0;
        drive(10'd1, 10'd5, 1'b1, 1'b1);
        for (int i = 0; i < 25; i++) begin
            step();
            drive_idle();
            if (o_dv[0] || o_dv[1] || o_le[0] || o_el[0]) ndv++;
        end
        n_chk++;
        if (ndv != 0) $display("FAIL filter_field1: got %0d active cycles want 0", ndv);
        else n_pass++;
        drive(10'd1, 10'd1, 1'b0, 1'b0);
        step();
        n_chk++;
        if (o_nf[0] !== 1'b1 || o_ef[0] !== 1'b0) $display("FAIL new_frame_pulse: got nf=%0d ef=%0d want 1 0", o_nf[0], o_ef[0]);
        else n_pass++;
        drive(10'd0, 10'd1, 1'b0, 1'b0);
        step();
        n_chk++;
        if (o_nf[0] !== 1'b0) $display("FAIL new_frame_width: got %0d want 0", o_nf[0]);
        else n_pass++;
        drive(10'd1, 10'd0, 1'b0, 1'b0);
        step();
        n_chk++;
        if (o_ef[0] !== 1'b1 || o_ef[2] !== 1'b0) $display("FAIL end_frame_pulse: got a=%0d c=%0d want 1 0", o_ef[0], o_ef[2]);
        else n_pass++;
        drive(10'd0, 10'd0, 1'b0, 1'b0);
        step();
        n_chk++;
        if (o_ef[0] !== 1'b0) $display("FAIL end_frame_width: got %0d want 0", o_ef[0]);
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        bit found = 1'b0;
        int ndv = 0;
        drive(10'd1, 10'd5, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
            drive_idle();
            if (o_dv[0] && o_x[0] == 10'd5) begin
                found = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!found) $display("FAIL rst_mid_reach_x5: got none want x=5");
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < NC; c++) begin
            n_chk++;
            if (obs[c] !== 42'd0) $display("FAIL rst_mid_async_cfg%0d: got %h want 0", c, obs[c]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            drive(10'($urandom_range(2, 700)), 10'd5, 1'b1, 1'b0);
            step();
            for (int c = 0; c < NC; c++) if (o_dv[c]) ndv++;
        end
        n_chk++;
        if (ndv != 0) $display("FAIL rst_mid_no_resume: got %0d strobes want 0", ndv);
        else n_pass++;
    endtask

    task automatic test_random();
        bit prev1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] xi;
            if (!prev1 && $urandom_range(0, 24) == 0) xi = 10'd1;
            else begin
                xi = 10'($urandom_range(0, 9));
                if (xi == 10'd1) xi = 10'd2;
            end
            prev1 = (xi == 10'd1);
            drive(xi, 10'($urandom_range(0, 4)), 1'($urandom_range(0, 3) != 0), 1'($urandom));
            step();
            for (int c = 0; c < NC; c++) begin
                n_chk++;
                if (obs[c] !== pk(c)) $display("FAIL random_model_cfg%0d cyc %0d: got %h want %h", c, i, obs[c], pk(c));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_mode2_y();
        test_line_err();
        test_field_filter();
        test_reset_midline();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tv_addr_win.md
TV_ADDR_WIN -- requirements
Module: tv_addr_win

Interface
REQ-001 Parameter DW, default 16, pixel data width.
REQ-002 Parameter XW, default 10, width of x counter.
REQ-003 Parameter YW, default 11, width of y output.
REQ-004 Parameter LINE_W, default 720, active pixels emitted per line.
REQ-005 Parameter PAD_W, default 3, zero pixels appended after active pixels; 0 allowed.
REQ-006 Parameter DECIM, default 2, clocks between emitted pixels; legal range 1..8.
REQ-007 Parameter FIELD_MODE, default 0: 0 = field 0 only, 1 = field 1 only, 2 = both fields interleaved.
REQ-008 clk  input  1  single clock; all state on rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 tv_x  input  10  decoder sample index within line.
REQ-011 tv_y  input  10  decoder line index within field.
REQ-012 tv_data  input  DW  decoder pixel data.
REQ-013 tv_dval  input  1  decoder data valid.
REQ-014 tv_field  input  1  decoder field flag.
REQ-015 x  output  XW  index of emitted pixel.
REQ-016 y  output  YW  line index of emitted pixel.
REQ-017 data_out  output  DW  emitted pixel; zero during padding.
REQ-018 dval  output  1  one-clock strobe per emitted pixel.
REQ-019 new_frame  output  1  one-clock frame-start pulse.
REQ-020 end_frame  output  1  one-clock frame-end pulse.
REQ-021 end_line  output  1  one-clock pulse coincident with last pixel of line.
REQ-022 line_err  output  1  one-clock pulse when a line restarts before completing.

Function
REQ-023 Field accepted: mode 0 -> tv_field==0; mode 1 -> tv_field==1; mode 2 -> either value.
REQ-024 Line start condition: tv_x==1 AND tv_dval==1 AND tv_y>=1 AND field accepted.
REQ-025 FSM states IDLE, ACTIVE, PAD; reset state IDLE.
REQ-026 IDLE, on line start: next clock dval=1, x=0, data_out=tv_data, phase counter=0; go ACTIVE.
REQ-027 y latched at line start: modes 0/1 -> tv_y-1; mode 2 -> 2*(tv_y-1)+tv_field; truncated to YW bits; held until next line start.
REQ-028 Phase counter increments each clock and wraps DECIM-1 -> 0; pixel emitted on each wrap, i.e. exactly DECIM clocks apart (every clock when DECIM=1).
REQ-029 ACTIVE emit: x increments by 1, data_out=tv_data sampled that clock, dval=1.
REQ-030 After pixel x=LINE_W-1 is emitted: go PAD if PAD_W>0, else IDLE.
REQ-031 PAD emit: same cadence, x continues LINE_W..LINE_W+PAD_W-1, data_out=0, dval=1; after last pad pixel, go IDLE.
REQ-032 end_line=1 together with the final dval of the line (x=LINE_W+PAD_W-1); zero otherwise.
REQ-033 data_out holds its last value when dval=0; x holds until next line start.
REQ-034 Line start while ACTIVE/PAD: line_err=1 for one clock; line restarts per REQ-026 in the same clock; no end_line for the aborted line.
REQ-035 new_frame=1 one clock after tv_x==1, tv_y==1, tv_field==(mode 1 ? 1 : 0).
REQ-036 end_frame=1 one clock after tv_x==1, tv_y==0, tv_field==(mode 0 ? 0 : 1).
REQ-037 new_frame and end_frame are single-clock pulses and independent of FSM state; tv_dval ignored once line started.
REQ-038 Lines from non-accepted fields produce no dval, end_line or line_err.

Reset
REQ-039 reset low: x=0, y=0, data_out=0, dval=0, new_frame=0, end_frame=0, end_line=0, line_err=0, phase=0, FSM=IDLE, asynchronously.
REQ-040 reset low mid-line discards the line; first activity after release requires a fresh line start.

Verification
REQ-041 LINE_W=8, PAD_W=2, DECIM=2, mode 0: line start at tv_y=5, tv_field=0 -> 10 dval strobes 2 clocks apart, x=0..9, y=4, data_out=0 at x=8,9, end_line with x=9.
REQ-042 DECIM=1, PAD_W=0, LINE_W=4: line start -> dval 4 consecutive clocks x=0..3, end_line at x=3, FSM IDLE next clock.
REQ-043 Mode 2: lines at tv_y=3 with tv_field=0 then tv_field=1 -> y=4 then y=5.
REQ-044 LINE_W=8, second line start after 3 pixels emitted -> line_err one clock, x restarts at 0, no end_line for aborted line.
REQ-045 Mode 0, tv_field=1 line start -> no dval; tv_x=1, tv_y=1, tv_field=0 -> new_frame single pulse; tv_x=1, tv_y=0, tv_field=0 -> end_frame single pulse.
REQ-046 reset asserted at x=5 -> all outputs 0 immediately; after release, no dval until next line start.
